ppu_result_checker: RTL

Synthesizable self-checking comparator for posit result streams. It buffers expected posit values in a FIFO, pops one per DUT result, and computes the posit-ordered absolute difference. It also tracks error count, total compared and maximum difference. It sits beside a ppu instance in on-chip/FPGA regression and replaces file-based diffing with a start/stop/done session.

---
 rtl/ppu_pkg.sv | 21 ++
 rtl/ppu_sync_fifo.sv | 53 +++++
 rtl/ppu_result_checker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared types and helpers for the posit result checker.
// Holds the session state encoding and the NaR bit pattern generator.
package ppu_pkg;

  // Widest posit word the helpers below can describe.
  localparam int unsigned MAX_N = 64;

  // Checker session states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // NaR for an n-bit posit: sign bit set, all other bits clear.
  function automatic logic [MAX_N-1:0] nar_pattern(input int unsigned n);
    nar_pattern = 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/ppu_sync_fifo.sv
// Generic synchronous FIFO with show-ahead output.
// dout is the oldest entry and is meaningful whenever empty is low.
// Push while full and pop while empty are ignored; clr empties the FIFO.
module ppu_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; clear has priority over any same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push && !clr && !rst) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ppu_result_checker.sv
// Self-checking comparator for posit result streams.
// Expected posits are buffered in a FIFO; each accepted DUT result pops one
// and the posit-ordered absolute difference is reported one cycle later,
// together with running error/compare counts and the session maximum diff.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready never depends on valid. exp_ready is high only in RUN
// with room in the FIFO; res_ready is high only in RUN/DRAIN with the FIFO
// non-empty, so a result is never accepted without an expected value.
module ppu_result_checker
  import ppu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned ES    = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TOL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [N-1:0]     exp_data,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [N-1:0]     res_data,
  output logic             diff_valid,
  output logic [N-1:0]     diff,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cmp_count,
  output logic [N-1:0]     max_diff,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam logic [N-1:0] NAR     = N'(nar_pattern(N));
  localparam logic [N-1:0] TOL_VEC = N'(TOL);

  // ES is carried only so this block can be paired with a matching ppu.
  if (ES > N - 3) begin : g_es_range
    $error("ppu_result_checker: ES too large for N");
  end

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_diff_valid;
  logic [N-1:0]     r_diff;
  logic             r_err_flag;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_cmp_count;
  logic [N-1:0]     r_max_diff;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [N-1:0]     w_fifo_dout;
  logic             w_push;
  logic             w_pop;
  logic [N:0]       w_sub;
  logic [N:0]       w_abs;
  logic [N-1:0]     w_diff;
  logic             w_err;
  logic             w_exp_nar;
  logic             w_res_nar;

  ppu_sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (w_push),
    .pop   (w_pop),
    .din   (exp_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign exp_ready = (r_state == ST_RUN) && !w_fifo_full;
  assign res_ready = r_busy && !w_fifo_empty;
  assign w_push    = exp_valid && exp_ready;
  assign w_pop     = res_valid && res_ready;

  // Posit order equals two's complement order, so subtract sign-extended
  // words at N+1 bits; the largest magnitude (2^N - 1) still fits in N bits.
  assign w_exp_nar = (w_fifo_dout == NAR);
  assign w_res_nar = (res_data == NAR);
  assign w_sub     = {w_fifo_dout[N-1], w_fifo_dout} - {res_data[N-1], res_data};
  assign w_abs     = w_sub[N] ? (~w_sub + (N+1)'(1)) : w_sub;

  // NaR is unordered: a matching NaR is exact, a lone NaR is the worst case.
  always_comb begin
    w_diff = w_abs[N-1:0];
    if (w_exp_nar && w_res_nar) begin
      w_diff = '0;
    end else if (w_exp_nar || w_res_nar) begin
      w_diff = '1;
    end
  end

  assign w_err = (w_diff > TOL_VEC);

  // Session FSM with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_state <= ST_RUN;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Emptiness is sampled before this edge's pop, so DONE follows
          // one edge after the final pop and its stats are already final.
          if (w_fifo_empty) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Compare result register and saturating session statistics.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_diff_valid <= 1'b0;
      r_diff       <= '0;
      r_err_flag   <= 1'b0;
      r_err_count  <= '0;
      r_cmp_count  <= '0;
      r_max_diff   <= '0;
    end else begin
      r_diff_valid <= w_pop;
      if (w_pop) begin
        r_diff     <= w_diff;
        r_err_flag <= w_err;
        if (r_cmp_count != {CNT_W{1'b1}}) begin
          r_cmp_count <= r_cmp_count + CNT_W'(1);
        end
        if (w_err && (r_err_count != {CNT_W{1'b1}})) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        if (w_diff > r_max_diff) begin
          r_max_diff <= w_diff;
        end
      end
    end
  end

  assign diff_valid = r_diff_valid;
  assign diff       = r_diff;
  assign err_flag   = r_err_flag;
  assign err_count  = r_err_count;
  assign cmp_count  = r_cmp_count;
  assign max_diff   = r_max_diff;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule
